// File: rtl/uart_pkg.sv
// uart_pkg: shared state type, frame constants and baud-divider helper
// for the buffered UART transmitter.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  localparam int DATA_BITS = 8;
  function automatic int clks_per_baud(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO, power-of-two depth.
// Ports: clk, rst_n (async active-low), wr_en/wr_data (push, ignored when full),
// rd_en/rd_data (pop, ignored when empty; rd_data shows the head word),
// full, empty, count (words stored).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_wr, do_rd;
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  // Extra pointer MSB tells a wrapped-full FIFO apart from an empty one.
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign count = wp - rp;
  assign rd_data = mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (do_wr) mem[wp[AW-1:0]] <= wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
    end
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: byte stream in, 8-bit LSB-first UART frames out via a FIFO.
// Ports: clk_100mhz, sys_rst_n (async active-low), data_in/valid_in/ready_out
// (byte stream, ready_out = FIFO not full), tx (registered line, idles high),
// busy (frame in progress or bytes queued), fifo_count (queued bytes, excluding
// the frame on the line).
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 16,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                        clk_100mhz,
  input  logic                        sys_rst_n,
  input  logic [7:0]                  data_in,
  input  logic                        valid_in,
  output logic                        ready_out,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int CPB = clks_per_baud(CLK_FREQ_HZ, BAUD);
  localparam int CW = $clog2(CPB);
  tx_state_t state;
  logic [CW-1:0] baud_cnt;
  logic [2:0] bit_cnt;
  logic [DATA_BITS-1:0] shreg, fifo_data;
  logic par, pend, full, empty, tick, last_stop, pop;
  assign tick = baud_cnt == CW'(CPB - 1);
  assign last_stop = bit_cnt == 3'(STOP_BITS - 1);
  // Idle starts wait on the registered non-empty flag, so a byte written at
  // edge k leaves on the line at k+2; back-to-back frames pop at stop end.
  assign pop = !empty && (state == IDLE ? pend : (state == STOP && tick && last_stop));
  assign ready_out = !full;
  assign busy = state != IDLE || fifo_count != '0;
  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_100mhz),
    .rst_n(sys_rst_n),
    .wr_en(valid_in),
    .wr_data(data_in),
    .rd_en(pop),
    .rd_data(fifo_data),
    .full(full),
    .empty(empty),
    .count(fifo_count)
  );
  always_ff @(posedge clk_100mhz or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state <= IDLE;
      baud_cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      par <= 1'b0;
      pend <= 1'b0;
      tx <= 1'b1;
    end else begin
      pend <= !empty;
      baud_cnt <= (pop || tick || state == IDLE) ? '0 : baud_cnt + 1'b1;
      if (pop) begin
        state <= START;
        tx <= 1'b0;
        shreg <= fifo_data;
        par <= ^fifo_data ^ 1'(PARITY_ODD);
        bit_cnt <= '0;
      end else if (tick) begin
        case (state)
          START: begin
            state <= DATA;
            tx <= shreg[0];
            shreg <= shreg >> 1;
          end
          DATA:
            if (bit_cnt == 3'(DATA_BITS - 1)) begin
              state <= PARITY_EN != 0 ? PARITY : STOP;
              tx <= PARITY_EN != 0 ? par : 1'b1;
              bit_cnt <= '0;
            end else begin
              tx <= shreg[0];
              shreg <= shreg >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          PARITY: begin
            state <= STOP;
            tx <= 1'b1;
          end
          STOP:
            if (last_stop) state <= IDLE;
            else bit_cnt <= bit_cnt + 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
endmodule
